// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the 32-bit ALU: captures decoded operands and control,
// applies EX/MEM and MEM/WB forwarding plus the immediate mux, and detects load-use hazards.
module id_ex_stage #(
  parameter int BITS_SIZE     = 32,
  parameter int REG_ADDR_BITS = 5
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic                     Stall,
  input  logic                     Flush,
  input  logic                     ID_Valid,
  input  logic [3:0]               ID_ALUControl,
  input  logic [BITS_SIZE-1:0]     ID_RsData,
  input  logic [BITS_SIZE-1:0]     ID_RtData,
  input  logic [BITS_SIZE-1:0]     ID_Imm,
  input  logic [REG_ADDR_BITS-1:0] ID_Rs,
  input  logic [REG_ADDR_BITS-1:0] ID_Rt,
  input  logic [REG_ADDR_BITS-1:0] ID_Rd,
  input  logic                     ID_ALUSrc,
  input  logic                     ID_RegDst,
  input  logic                     ID_RegWrite,
  input  logic                     ID_MemRead,
  input  logic                     ID_MemWrite,
  input  logic                     ID_MemToReg,
  input  logic                     MEM_RegWrite,
  input  logic [REG_ADDR_BITS-1:0] MEM_WriteReg,
  input  logic [BITS_SIZE-1:0]     MEM_ALUResult,
  input  logic                     WB_RegWrite,
  input  logic [REG_ADDR_BITS-1:0] WB_WriteReg,
  input  logic [BITS_SIZE-1:0]     WB_WriteData,
  output logic                     EX_Valid,
  output logic [3:0]               EX_ALUControl,
  output logic [BITS_SIZE-1:0]     EX_A,
  output logic [BITS_SIZE-1:0]     EX_B,
  output logic [BITS_SIZE-1:0]     EX_StoreData,
  output logic [REG_ADDR_BITS-1:0] EX_WriteReg,
  output logic                     EX_RegWrite,
  output logic                     EX_MemRead,
  output logic                     EX_MemWrite,
  output logic                     EX_MemToReg,
  output logic                     LoadUseHazard
);

  typedef struct packed {
    logic                     valid;
    logic [3:0]               alu_ctrl;
    logic [BITS_SIZE-1:0]     rs_data;
    logic [BITS_SIZE-1:0]     rt_data;
    logic [BITS_SIZE-1:0]     imm;
    logic [REG_ADDR_BITS-1:0] rs;
    logic [REG_ADDR_BITS-1:0] rt;
    logic [REG_ADDR_BITS-1:0] write_reg;
    logic                     alu_src;
    logic                     reg_write;
    logic                     mem_read;
    logic                     mem_write;
    logic                     mem_to_reg;
  } ex_state_t;

  localparam int ST_W = $bits(ex_state_t);
  localparam logic [REG_ADDR_BITS-1:0] REG_ZERO = {REG_ADDR_BITS{1'b0}};

  ex_state_t              state_r;
  ex_state_t              capture_s;
  logic [BITS_SIZE-1:0]   fwd_rs_s;
  logic [BITS_SIZE-1:0]   fwd_rt_s;

  // MEM result wins over WB; register 0 is hard-wired and never forwarded.
  function automatic logic [BITS_SIZE-1:0] fwd_sel(
    input logic [REG_ADDR_BITS-1:0] src,
    input logic [BITS_SIZE-1:0]     reg_data,
    input logic                     mem_rw,
    input logic [REG_ADDR_BITS-1:0] mem_wr,
    input logic [BITS_SIZE-1:0]     mem_val,
    input logic                     wb_rw,
    input logic [REG_ADDR_BITS-1:0] wb_wr,
    input logic [BITS_SIZE-1:0]     wb_val
  );
    logic [BITS_SIZE-1:0] res;
    if (mem_rw && (mem_wr != REG_ZERO) && (mem_wr == src)) begin
      res = mem_val;
    end else if (wb_rw && (wb_wr != REG_ZERO) && (wb_wr == src)) begin
      res = wb_val;
    end else begin
      res = reg_data;
    end
    return res;
  endfunction

  // Assemble the entry that a normal capture would load.
  always_comb begin
    capture_s            = {ST_W{1'b0}};
    capture_s.valid      = ID_Valid;
    capture_s.alu_ctrl   = ID_ALUControl;
    capture_s.rs_data    = ID_RsData;
    capture_s.rt_data    = ID_RtData;
    capture_s.imm        = ID_Imm;
    capture_s.rs         = ID_Rs;
    capture_s.rt         = ID_Rt;
    capture_s.write_reg  = ID_RegDst ? ID_Rd : ID_Rt;
    capture_s.alu_src    = ID_ALUSrc;
    capture_s.reg_write  = ID_RegWrite;
    capture_s.mem_read   = ID_MemRead;
    capture_s.mem_write  = ID_MemWrite;
    capture_s.mem_to_reg = ID_MemToReg;
  end

  // Pipeline register: reset > stall > bubble (flush/hazard) > capture.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_r <= {ST_W{1'b0}};
    end else if (Stall) begin
      state_r <= state_r;
    end else if (Flush || LoadUseHazard) begin
      state_r <= {ST_W{1'b0}};
    end else begin
      state_r <= capture_s;
    end
  end

  // Hazard looks at the registered load against the instruction waiting in ID.
  always_comb begin
    LoadUseHazard = state_r.valid && state_r.mem_read &&
                    (state_r.write_reg != REG_ZERO) && ID_Valid &&
                    ((state_r.write_reg == ID_Rs) || (state_r.write_reg == ID_Rt));
  end

  // Operand forwarding and immediate selection; the immediate is never forwarded.
  always_comb begin
    fwd_rs_s = fwd_sel(state_r.rs, state_r.rs_data, MEM_RegWrite, MEM_WriteReg,
                       MEM_ALUResult, WB_RegWrite, WB_WriteReg, WB_WriteData);
    fwd_rt_s = fwd_sel(state_r.rt, state_r.rt_data, MEM_RegWrite, MEM_WriteReg,
                       MEM_ALUResult, WB_RegWrite, WB_WriteReg, WB_WriteData);
    EX_A         = fwd_rs_s;
    EX_StoreData = fwd_rt_s;
    if (state_r.alu_src) begin
      EX_B = state_r.imm;
    end else begin
      EX_B = fwd_rt_s;
    end
  end

  assign EX_Valid      = state_r.valid;
  assign EX_ALUControl = state_r.alu_ctrl;
  assign EX_WriteReg   = state_r.write_reg;
  assign EX_RegWrite   = state_r.reg_write;
  assign EX_MemRead    = state_r.mem_read;
  assign EX_MemWrite   = state_r.mem_write;
  assign EX_MemToReg   = state_r.mem_to_reg;

endmodule
